canvas_wr: RTL and testbench
============================

Name: canvas_wr

Overview:
- Pixel-writer engine for the 12-bit RGB canvas frame buffer, H_LEN x V_LEN, linear address y*H_LEN+x.
- It is the write side of the canvas memory, whose read side is the display path.
- Accepts one command at a time over a valid/ready handshake: rectangle fill or full-canvas clear.
- Emits one write per pclk on the frame buffer write port and signals completion.

Parameters:
- DW, 15, frame-buffer address width.
- H_LEN, 200, canvas width in pixels.
- V_LEN, 150, canvas height in pixels.
- CW, 8, coordinate/size field width; must satisfy 2^CW > max(H_LEN, V_LEN).

Ports:
- pclk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  2  0=NOP, 1=FILL, 2=CLEAR, 3=reserved (treated as NOP).
- cmd_x  in  CW  rectangle left column.
- cmd_y  in  CW  rectangle top row.
- cmd_w  in  CW  rectangle width.
- cmd_h  in  CW  rectangle height.
- cmd_color  in  12  RGB444 fill value {R,G,B}.
- we  out  1  frame-buffer write enable.
- waddr  out  DW  frame-buffer write address.
- wdata  out  12  frame-buffer write data.
- busy  out  1  command in progress (state != IDLE).
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse coincident with done when a command was rejected.

Behaviour:
- Reset values: cmd_ready=1, we=0, waddr=0, wdata=0, busy=0, done=0, err=0; state=IDLE; all counters 0.
- Handshake:
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - cmd_ready=1 only in IDLE. All cmd_* fields are captured at acceptance; later changes are ignored.
- States and transitions:
  - IDLE -> SETUP on acceptance.
  - SETUP (exactly 1 cycle): computes the base address cmd_y*H_LEN+cmd_x (the only multiply), the range check, and loads the column/row counters. Goes to RUN, or to DONE if there are zero writes or the command is rejected.
  - RUN: one write per cycle. Goes to DONE after the last write.
  - DONE (1 cycle): done=1, err as computed. Then returns to IDLE.
- Write outputs: we, waddr and wdata are registered.
  - For a command accepted at edge E0: SETUP occupies E0..E1, and we is first high after E1.
  - A FILL of w*h pixels keeps we high for exactly w*h consecutive cycles, with no gaps.
  - done is high in the cycle after the last we cycle.
- FILL order is raster: row by row, left to right.
  - waddr advances by +1 within a row.
  - At end of row: waddr = waddr + H_LEN - w + 1.
  - No multiplier is used in RUN.
- CLEAR ignores the x/y/w/h fields and writes cmd_color to addresses 0..H_LEN*V_LEN-1 in order: H_LEN*V_LEN write cycles.
- NOP and reserved ops: IDLE -> SETUP -> DONE with no writes; done=1, err=0.
- Zero size (w==0 or h==0): no writes; done=1, err=0.
- Out of range (cmd_x+cmd_w > H_LEN or cmd_y+cmd_h > V_LEN, computed in CW+1 bits): behaviour depends on the optional feature below.
- Reset mid-operation: on the rstn-low edge, we drops to 0 and the state returns to IDLE. The partial rectangle stays in memory. No done pulse is issued.
- wdata holds cmd_color for the whole command. waddr holds its last value while we=0.

Optional Feature:
- Macro: CANVAS_WR_CLIP_EN.
- Defined:
  - Out-of-range rectangles are clipped: effective w = min(cmd_w, H_LEN-cmd_x), effective h = min(cmd_h, V_LEN-cmd_y).
  - cmd_x >= H_LEN or cmd_y >= V_LEN yields a zero-size command.
  - err is never asserted.
- Undefined:
  - Out-of-range commands perform no writes and complete with done=1, err=1.

Decomposition:
- Shared package canvas_pkg holds:
  - H_LEN, V_LEN, DW.
  - Op codes OP_NOP, OP_FILL, OP_CLEAR.
  - State encoding S_IDLE, S_SETUP, S_RUN, S_DONE.
- One natural sub-module: canvas_wr_addr_gen.
  - Holds the row/column counters and the incremental waddr.
  - Its last-pixel flag drives the FSM.
- The FSM and handshake stay in canvas_wr.

Test Plan:
- Reset, then FILL x=10,y=2,w=3,h=2,color=12'hF00:
  - writes exactly to addresses 410,411,412,610,611,612, in 6 consecutive we cycles starting 2 cycles after acceptance;
  - done 1 cycle later, err=0.
- CLEAR color=12'h000:
  - 30000 consecutive writes to addresses 0..29999;
  - cmd_ready=0 throughout, done once.
- FILL x=198,y=0,w=5,h=1:
  - without the macro, no we and done+err together;
  - with CANVAS_WR_CLIP_EN, writes to addresses 198 and 199 only, err=0.
- FILL w=0,h=7, and op=3:
  - no we; done pulse 2 cycles after acceptance; err=0.
- Hold cmd_valid=1 during a 4x4 FILL while changing the fields:
  - the second command is accepted only on the cycle after done;
  - the first command's writes use the original fields.
- Assert rstn=0 midway through a 20x20 FILL:
  - we=0 and cmd_ready=1 after the reset edge, no done;
  - the next FILL completes normally.

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared constants, op codes, state encoding and command payload for the canvas pixel writer.
package canvas_pkg;

  localparam int unsigned H_LEN = 200;
  localparam int unsigned V_LEN = 150;
  localparam int unsigned DW    = 15;
  localparam int unsigned CW    = 8;
  localparam int unsigned CLR_W = 12;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_FILL  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [CW-1:0]    x;
    logic [CW-1:0]    y;
    logic [CW-1:0]    w;
    logic [CW-1:0]    h;
    logic [CLR_W-1:0] color;
  } cmd_t;

  // True when [pos, pos+len) lies inside [0, lim); evaluated one bit wider than CW.
  function automatic logic span_fits(input logic [CW-1:0] pos,
                                     input logic [CW-1:0] len,
                                     input logic [CW-1:0] lim);
    return ({1'b0, pos} + {1'b0, len}) <= {1'b0, lim};
  endfunction

  // Length of the span after trimming it to [0, lim); zero when it starts outside.
  function automatic logic [CW-1:0] clip_len(input logic [CW-1:0] pos,
                                             input logic [CW-1:0] len,
                                             input logic [CW-1:0] lim);
    logic [CW-1:0] res;
    if (pos >= lim)                      res = '0;
    else if (!span_fits(pos, len, lim))  res = lim - pos;
    else                                 res = len;
    return res;
  endfunction

endpackage

// File: rtl/canvas_wr_if.sv
// Command handshake and frame-buffer write port of the canvas pixel writer.
interface canvas_wr_if;
  import canvas_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CW-1:0]    cmd_x;
  logic [CW-1:0]    cmd_y;
  logic [CW-1:0]    cmd_w;
  logic [CW-1:0]    cmd_h;
  logic [CLR_W-1:0] cmd_color;
  logic             we;
  logic [DW-1:0]    waddr;
  logic [CLR_W-1:0] wdata;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, we, waddr, wdata, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, we, waddr, wdata, busy, done, err
  );

endinterface

// File: rtl/canvas_wr_addr_gen.sv
// Raster address walker: column/row down-counters and an add-only incremental write address.
module canvas_wr_addr_gen
  import canvas_pkg::*;
(
  input  logic          pclk,
  input  logic          rstn,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] base,
  input  logic [CW-1:0] len_w,
  input  logic [CW-1:0] len_h,
  output logic [DW-1:0] waddr,
  output logic          last_c
);

  logic [CW-1:0] col_q;
  logic [CW-1:0] row_q;
  logic [CW-1:0] wrap_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] row_step_q;

  // Both counters exhausted: the address on the port is the final pixel.
  assign last_c = (col_q == '0) && (row_q == '0);
  assign waddr  = addr_q;

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      col_q      <= '0;
      row_q      <= '0;
      wrap_q     <= '0;
      addr_q     <= '0;
      row_step_q <= '0;
    end else if (load) begin
      addr_q     <= base;
      col_q      <= len_w - CW'(1);
      row_q      <= len_h - CW'(1);
      wrap_q     <= len_w - CW'(1);
      row_step_q <= DW'(H_LEN) - DW'(len_w) + DW'(1);
    end else if (step) begin
      if (col_q == '0) begin
        // End of row: jump to the left edge of the next row.
        col_q  <= wrap_q;
        row_q  <= row_q - CW'(1);
        addr_q <= addr_q + row_step_q;
      end else begin
        col_q  <= col_q - CW'(1);
        addr_q <= addr_q + DW'(1);
      end
    end
  end

endmodule

// File: rtl/canvas_wr.sv
// Canvas frame-buffer pixel writer: rectangle fill and full clear, one write per pclk.
// Optional build macro CANVAS_WR_CLIP_EN clips out-of-range rectangles instead of rejecting them.
module canvas_wr
  import canvas_pkg::*;
(
  input  logic       pclk,
  input  logic       rstn,
  canvas_wr_if.slave bus
);

  state_t        state;
  state_t        state_nxt;
  cmd_t          cap_q;

  logic          ready_q, ready_nxt;
  logic          busy_q,  busy_nxt;
  logic          done_q,  done_nxt;
  logic          err_q,   err_nxt;
  logic          we_q,    we_nxt;
  logic          accept;

  logic [CW-1:0] eff_w;
  logic [CW-1:0] eff_h;
  logic [DW-1:0] base;
  logic          reject;
  logic          go_run;

  logic          ag_load;
  logic          ag_step;
  logic          ag_last_c;
  logic [DW-1:0] ag_waddr;

  // Command capture; fields are frozen for the life of the command.
  always_ff @(posedge pclk) begin
    if (!rstn) begin
      cap_q <= '0;
    end else if (accept) begin
      cap_q <= '{op:    bus.cmd_op,
                 x:     bus.cmd_x,
                 y:     bus.cmd_y,
                 w:     bus.cmd_w,
                 h:     bus.cmd_h,
                 color: bus.cmd_color};
    end
  end

  // Setup datapath: base address, effective extent and range check from the captured command.
  always_comb begin
    eff_w  = '0;
    eff_h  = '0;
    base   = '0;
    reject = 1'b0;
    case (cap_q.op)
      OP_FILL: begin
        base = DW'(cap_q.y) * DW'(H_LEN) + DW'(cap_q.x);
`ifdef CANVAS_WR_CLIP_EN
        eff_w = clip_len(cap_q.x, cap_q.w, CW'(H_LEN));
        eff_h = clip_len(cap_q.y, cap_q.h, CW'(V_LEN));
`else
        eff_w  = cap_q.w;
        eff_h  = cap_q.h;
        reject = !span_fits(cap_q.x, cap_q.w, CW'(H_LEN)) ||
                 !span_fits(cap_q.y, cap_q.h, CW'(V_LEN));
`endif
      end
      OP_CLEAR: begin
        eff_w = CW'(H_LEN);
        eff_h = CW'(V_LEN);
      end
      default: ;
    endcase
    go_run = !reject && (eff_w != '0) && (eff_h != '0);
  end

  // State and registered outputs.
  always_ff @(posedge pclk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= ready_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      we_q    <= we_nxt;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ag_load   = 1'b0;
    we_nxt    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          accept    = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (go_run) begin
          ag_load   = 1'b1;
          we_nxt    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          done_nxt  = 1'b1;
          err_nxt   = reject;
          state_nxt = S_DONE;
        end
      end
      S_RUN: begin
        if (ag_last_c) begin
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          we_nxt    = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    ready_nxt = (state_nxt == S_IDLE);
    busy_nxt  = (state_nxt != S_IDLE);
  end

  // Advance only past non-final pixels so the address holds after the last write.
  assign ag_step = (state == S_RUN) && !ag_last_c;

  canvas_wr_addr_gen u_addr_gen (
    .pclk   (pclk),
    .rstn   (rstn),
    .load   (ag_load),
    .step   (ag_step),
    .base   (base),
    .len_w  (eff_w),
    .len_h  (eff_h),
    .waddr  (ag_waddr),
    .last_c (ag_last_c)
  );

  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.we        = we_q;
  assign bus.waddr     = ag_waddr;
  assign bus.wdata     = cap_q.color;

endmodule

// File: tb/tb_canvas_wr.sv
// Self-checking bench for canvas_wr: write scoreboard plus per-scenario timing and status checks.
module tb_canvas_wr;
  import canvas_pkg::*;

  localparam int HL = int'(H_LEN);
  localparam int VL = int'(V_LEN);

  typedef struct packed {
    logic [DW-1:0]    addr;
    logic [CLR_W-1:0] data;
  } wr_t;

  logic pclk = 1'b0;
  logic rstn = 1'b0;
  canvas_wr_if bus ();

  canvas_wr dut (
    .pclk (pclk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 pclk = ~pclk;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  int  we_cnt, first_we, last_we, done_cnt, done_cyc;
  logic done_err;

  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: samples 1 time unit after each edge, pops the scoreboard on every write.
  always @(posedge pclk) begin
    wr_t e;
    #1;
    if (bus.we === 1'b1) begin
      we_cnt++;
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", bus.waddr, bus.wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.waddr !== e.addr || bus.wdata !== e.data || bus.cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h ready=%b, required addr=%0d data=%h ready=0",
                   bus.waddr, bus.wdata, bus.cmd_ready, e.addr, e.data);
        end
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = bus.err;
    end else if (bus.err !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL err_without_done: got err=%b, required 0", bus.err);
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic clr_stats();
    we_cnt   = 0;
    first_we = -1;
    last_we  = -1;
    done_cnt = 0;
    done_cyc = -1;
    done_err = 1'b0;
  endtask

  task automatic push_wr(input int a, input logic [CLR_W-1:0] c);
    wr_t e;
    e.addr = DW'(a);
    e.data = c;
    exp_q.push_back(e);
  endtask

  // Reference rectangle: direct y*H_LEN+x per pixel, with optional clipping.
  task automatic push_rect(input int x, input int y, input int w, input int h, input logic [CLR_W-1:0] c);
`ifdef CANVAS_WR_CLIP_EN
    if (x >= HL || y >= VL) w = 0;
    else begin
      if (x + w > HL) w = HL - x;
      if (y + h > VL) h = VL - y;
    end
`else
    if (x + w > HL || y + h > VL) return;
`endif
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++)
        push_wr((y + r) * HL + (x + k), c);
  endtask

  task automatic send(input logic [1:0] op, input int x, input int y, input int w, input int h,
                      input logic [CLR_W-1:0] c, input bit hold, output int acc);
    bus.cmd_op    = op;
    bus.cmd_x     = CW'(x);
    bus.cmd_y     = CW'(y);
    bus.cmd_w     = CW'(w);
    bus.cmd_h     = CW'(h);
    bus.cmd_color = c;
    bus.cmd_valid = 1'b1;
    for (int n = 0; n < 200 && bus.cmd_ready !== 1'b1; n++) begin
      @(posedge pclk); #2;
    end
    if (bus.cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got cmd_ready=%b, required 1", bus.cmd_ready);
    end
    @(posedge pclk); #2;
    acc = cyc;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int n = 0; n < budget && done_cnt < target; n++) begin
      @(posedge pclk); #2;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d done pulses, required %0d", done_cnt, target);
    end
    repeat (2) @(posedge pclk);
    #2;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0; bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0;
    bus.cmd_color = '0;
    rstn = 1'b0;
    clr_stats();
    repeat (3) @(posedge pclk);
    #2;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.we !== 1'b0 || bus.waddr !== '0 || bus.wdata !== '0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b we=%b waddr=%0d wdata=%h busy=%b done=%b err=%b, required 1 0 0 000 0 0 0",
               bus.cmd_ready, bus.we, bus.waddr, bus.wdata, bus.busy, bus.done, bus.err);
    end
    rstn = 1'b1;
    @(posedge pclk); #2;
  endtask

  task automatic test_fill_basic();
    int acc;
    int addrs[6] = '{410, 411, 412, 610, 611, 612};
    clr_stats();
    foreach (addrs[i]) push_wr(addrs[i], 12'hF00);
    send(OP_FILL, 10, 2, 3, 2, 12'hF00, 1'b0, acc);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL fill_busy: got %b, required 1", bus.busy);
    end
    wait_done(1, 50);
    checks++;
    if (first_we !== acc + 1) begin
      errors++; $display("FAIL fill_first_we: got cycle %0d, required %0d", first_we, acc + 1);
    end
    checks++;
    if (we_cnt !== 6 || last_we - first_we !== 5) begin
      errors++; $display("FAIL fill_we_run: got %0d writes over span %0d, required 6 over 5", we_cnt, last_we - first_we);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== last_we + 1 || done_err !== 1'b0) begin
      errors++; $display("FAIL fill_done: got cnt=%0d cyc=%0d err=%b, required 1 %0d 0", done_cnt, done_cyc, done_err, last_we + 1);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL fill_left: got %0d pending writes, required 0", exp_q.size());
    end
  endtask

  task automatic test_clear();
    int acc;
    clr_stats();
    for (int a = 0; a < HL * VL; a++) push_wr(a, 12'h000);
    send(OP_CLEAR, 7, 9, 3, 3, 12'h000, 1'b0, acc);
    wait_done(1, HL * VL + 50);
    checks++;
    if (we_cnt !== HL * VL || first_we !== acc + 1 || last_we - first_we !== HL * VL - 1) begin
      errors++; $display("FAIL clear_we_run: got %0d writes from %0d to %0d, required %0d from %0d",
                         we_cnt, first_we, last_we, HL * VL, acc + 1);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== last_we + 1 || done_err !== 1'b0) begin
      errors++; $display("FAIL clear_done: got cnt=%0d cyc=%0d err=%b, required 1 %0d 0", done_cnt, done_cyc, done_err, last_we + 1);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL clear_left: got %0d pending writes, required 0", exp_q.size());
    end
  endtask

  task automatic test_out_of_range();
    int acc;
    clr_stats();
    push_rect(198, 0, 5, 1, 12'h0AB);
    send(OP_FILL, 198, 0, 5, 1, 12'h0AB, 1'b0, acc);
    wait_done(1, 50);
`ifdef CANVAS_WR_CLIP_EN
    checks++;
    if (we_cnt !== 2 || done_err !== 1'b0 || done_cyc !== acc + 3) begin
      errors++; $display("FAIL oor_clip: got writes=%0d err=%b done_cyc=%0d, required 2 0 %0d", we_cnt, done_err, done_cyc, acc + 3);
    end
`else
    checks++;
    if (we_cnt !== 0 || done_err !== 1'b1 || done_cyc !== acc + 1) begin
      errors++; $display("FAIL oor_reject: got writes=%0d err=%b done_cyc=%0d, required 0 1 %0d", we_cnt, done_err, done_cyc, acc + 1);
    end
`endif
    checks++;
    if (done_cnt !== 1 || exp_q.size() !== 0) begin
      errors++; $display("FAIL oor_done: got cnt=%0d pending=%0d, required 1 0", done_cnt, exp_q.size());
    end
  endtask

  task automatic test_zero_and_nop();
    int acc;
    logic [1:0] ops[3] = '{OP_FILL, 2'd3, OP_NOP};
    foreach (ops[i]) begin
      clr_stats();
      send(ops[i], 30, 40, 0, 7, 12'h5A5, 1'b0, acc);
      wait_done(1, 20);
      checks++;
      if (we_cnt !== 0 || done_cnt !== 1 || done_cyc !== acc + 1 || done_err !== 1'b0) begin
        errors++; $display("FAIL zero_op%0d: got writes=%0d done=%0d cyc=%0d err=%b, required 0 1 %0d 0",
                           ops[i], we_cnt, done_cnt, done_cyc, done_err, acc + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc_a, acc_b, ready_cyc;
    clr_stats();
    push_rect(20, 5, 4, 4, 12'h0F0);
    send(OP_FILL, 20, 5, 4, 4, 12'h0F0, 1'b1, acc_a);
    bus.cmd_x = CW'(40); bus.cmd_y = CW'(10); bus.cmd_w = CW'(2); bus.cmd_h = CW'(2);
    bus.cmd_color = 12'h00F;
    push_rect(40, 10, 2, 2, 12'h00F);
    for (int n = 0; n < 100 && bus.cmd_ready !== 1'b1; n++) begin
      @(posedge pclk); #2;
    end
    ready_cyc = cyc;
    checks++;
    if (done_cnt !== 1 || ready_cyc !== done_cyc + 1 || done_cyc !== acc_a + 17) begin
      errors++; $display("FAIL b2b_ready: got ready_cyc=%0d done_cyc=%0d done_cnt=%0d, required %0d %0d 1",
                         ready_cyc, done_cyc, done_cnt, acc_a + 18, acc_a + 17);
    end
    @(posedge pclk); #2;
    acc_b = cyc;
    bus.cmd_valid = 1'b0;
    wait_done(2, 50);
    checks++;
    if (we_cnt !== 20 || done_cnt !== 2 || done_cyc !== acc_b + 5 || exp_q.size() !== 0) begin
      errors++; $display("FAIL b2b_second: got writes=%0d done=%0d cyc=%0d pending=%0d, required 20 2 %0d 0",
                         we_cnt, done_cnt, done_cyc, exp_q.size(), acc_b + 5);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    clr_stats();
    push_rect(50, 50, 20, 20, 12'h777);
    send(OP_FILL, 50, 50, 20, 20, 12'h777, 1'b0, acc);
    repeat (150) @(posedge pclk);
    #2;
    rstn = 1'b0;
    @(posedge pclk); #2;
    checks++;
    if (bus.we !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midreset_state: got we=%b ready=%b busy=%b, required 0 1 0", bus.we, bus.cmd_ready, bus.busy);
    end
    rstn = 1'b1;
    repeat (5) @(posedge pclk);
    #2;
    checks++;
    if (done_cnt !== 0 || we_cnt !== 150 || exp_q.size() !== 250) begin
      errors++; $display("FAIL midreset_partial: got done=%0d writes=%0d pending=%0d, required 0 150 250",
                         done_cnt, we_cnt, exp_q.size());
    end
    exp_q.delete();
    clr_stats();
    push_rect(5, 100, 3, 3, 12'h0AF);
    send(OP_FILL, 5, 100, 3, 3, 12'h0AF, 1'b0, acc);
    wait_done(1, 50);
    checks++;
    if (we_cnt !== 9 || done_cnt !== 1 || done_err !== 1'b0 || first_we !== acc + 1 || exp_q.size() !== 0) begin
      errors++; $display("FAIL midreset_next: got writes=%0d done=%0d err=%b first=%0d pending=%0d, required 9 1 0 %0d 0",
                         we_cnt, done_cnt, done_err, first_we, exp_q.size(), acc + 1);
    end
  endtask

  initial begin
    test_reset();
    test_fill_basic();
    test_clear();
    test_out_of_range();
    test_zero_and_nop();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
